// File: rtl/qdec_ctx_arb.sv
// Context-memory arbiter for an entropy decoder: sequences a bulk table init, then
// shares one single-port RAM between decoder reads and state writebacks.
module qdec_ctx_arb #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 8,
   parameter int CTX_NUM = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_start,
   input  logic [DATA_W-1:0] init_data,
   input  logic              init_vld,
   output logic              init_rdy,
   output logic              init_busy,
   output logic              init_done,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_vld,
   output logic              rd_rdy,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_vld,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              wb_vld,
   output logic              wb_rdy,
   output logic [ADDR_W-1:0] ctx_addr,
   output logic [DATA_W-1:0] ctx_wdata,
   output logic              ctx_we,
   output logic              ctx_re,
   input  logic [DATA_W-1:0] ctx_rdata
);

   typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CTX_NUM - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [1:0]          starve_q, starve_d;
   logic                rsp_mem_q, rsp_mem_d;
   logic                rsp_byp_q, rsp_byp_d;
   logic [DATA_W-1:0]   byp_data_q, byp_data_d;
   logic [DATA_W-1:0]   rd_hold_q, rd_hold_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                same_addr;

   assign same_addr = (rd_addr == wb_addr);

   // Next-state, grant and memory-port decode.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      starve_d   = 2'd0;
      rsp_mem_d  = 1'b0;
      rsp_byp_d  = 1'b0;
      byp_data_d = byp_data_q;
      init_rdy   = 1'b0;
      init_busy  = 1'b0;
      init_done  = 1'b0;
      rd_rdy     = 1'b0;
      wb_rdy     = 1'b0;
      ctx_we     = 1'b0;
      ctx_re     = 1'b0;
      ctx_addr   = addr_q;
      ctx_wdata  = wdata_q;

      unique case (state_q)
         IDLE: begin
            if (init_start) begin
               state_d = INIT;
               cnt_d   = '0;
            end
         end

         INIT: begin
            init_rdy  = 1'b1;
            init_busy = 1'b1;
            if (init_vld) begin
               ctx_we    = 1'b1;
               ctx_addr  = cnt_q;
               ctx_wdata = init_data;
            end
            // A restart wins over completion so an aborted pass never reports done.
            if (init_start) begin
               cnt_d = '0;
            end else if (init_vld) begin
               if (cnt_q == LAST_IDX) begin
                  init_done = 1'b1;
                  state_d   = RUN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         RUN: begin
            if (init_start) begin
               state_d = INIT;
               cnt_d   = '0;
            end
            if (rd_vld && wb_vld && same_addr) begin
               // Read and write of one entry: the write goes to memory, the read is forwarded.
               rd_rdy     = 1'b1;
               wb_rdy     = 1'b1;
               ctx_we     = 1'b1;
               ctx_addr   = wb_addr;
               ctx_wdata  = wb_data;
               rsp_byp_d  = 1'b1;
               byp_data_d = wb_data;
            end else if (rd_vld && ((starve_q == 2'd2) || !wb_vld)) begin
               rd_rdy    = 1'b1;
               ctx_re    = 1'b1;
               ctx_addr  = rd_addr;
               rsp_mem_d = 1'b1;
            end else if (wb_vld) begin
               wb_rdy    = 1'b1;
               ctx_we    = 1'b1;
               ctx_addr  = wb_addr;
               ctx_wdata = wb_data;
               if (rd_vld) begin
                  starve_d = starve_q + 2'd1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Read response: forwarded data, fresh memory data, or the last value held.
   always_comb begin
      rd_data_vld = rsp_mem_q | rsp_byp_q;
      if (rsp_byp_q) begin
         rd_data = byp_data_q;
      end else if (rsp_mem_q) begin
         rd_data = ctx_rdata;
      end else begin
         rd_data = rd_hold_q;
      end
   end

   assign rd_hold_d = rd_data;
   assign addr_d    = ctx_addr;
   assign wdata_d   = ctx_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         starve_q   <= 2'd0;
         rsp_mem_q  <= 1'b0;
         rsp_byp_q  <= 1'b0;
         byp_data_q <= '0;
         rd_hold_q  <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         rsp_mem_q  <= rsp_mem_d;
         rsp_byp_q  <= rsp_byp_d;
         byp_data_q <= byp_data_d;
         rd_hold_q  <= rd_hold_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

endmodule
